// File: rtl/i2c_master_ctrl.sv
// I2C master control: divides clk into SCL and sequences start, address+R/W, ack, data, ack, stop.
// Optional macro I2C_MULTI_BYTE_EN: a held enable chains further data bytes from the ack states.
module i2c_master_ctrl #(
    parameter int CLK_DIV = 4   // clk cycles per SCL half-period, must be >= 2
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       enable,
    input  logic       rw,
    input  logic       sda_in,
    output logic [7:0] state,
    output logic [3:0] count,
    output logic       i2c_scl_en,
    output logic       i2c_scl,
    output logic       scl_negedge,
    output logic       busy,
    output logic       done,
    output logic       ack_err
);
    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [7:0] {
        IDLE       = 8'd0,
        START      = 8'd1,
        ADDRESS    = 8'd2,
        READ_ACK   = 8'd3,
        WRITE_DATA = 8'd4,
        READ_ACK2  = 8'd5,
        READ_DATA  = 8'd6,
        WRITE_ACK2 = 8'd7,
        STOP       = 8'd8
    } state_t;

    state_t           state_q;
    logic [3:0]       count_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic             scl_q, scl_d;
    logic             rw_q;
    logic             scl_en_q;
    logic             busy_q;
    logic             done_q;
    logic             ack_err_q;
    logic             rise_tick;

    always_comb begin
        div_d = div_q + DIV_W'(1);
        scl_d = scl_q;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            scl_d = ~scl_q;
        end
    end

    // The FSM only moves when scl_int is about to go high, so the datapath sees stable inputs at every fall.
    assign rise_tick = (div_q == DIV_LAST) && !scl_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            div_q     <= '0;
            scl_q     <= 1'b1;
            state_q   <= IDLE;
            count_q   <= 4'd0;
            rw_q      <= 1'b0;
            scl_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            scl_q  <= scl_d;
            done_q <= 1'b0;
            if (rise_tick) begin
                case (state_q)
                    IDLE: begin
                        if (enable) begin
                            state_q   <= START;
                            rw_q      <= rw;
                            busy_q    <= 1'b1;
                            ack_err_q <= 1'b0;
                        end
                    end
                    START: begin
                        state_q  <= ADDRESS;
                        count_q  <= 4'd7;
                        scl_en_q <= 1'b1;
                    end
                    ADDRESS: begin
                        if (count_q != 4'd0) count_q <= count_q - 4'd1;
                        else                 state_q <= READ_ACK;
                    end
                    READ_ACK: begin
                        if (!sda_in) begin
                            state_q <= rw_q ? READ_DATA : WRITE_DATA;
                            count_q <= 4'd7;
                        end else begin
                            ack_err_q <= 1'b1;
                            state_q   <= STOP;
                            scl_en_q  <= 1'b0;
                        end
                    end
                    WRITE_DATA: begin
                        if (count_q != 4'd0) count_q <= count_q - 4'd1;
                        else                 state_q <= READ_ACK2;
                    end
                    READ_ACK2: begin
`ifdef I2C_MULTI_BYTE_EN
                        if (!sda_in && enable) begin
                            state_q <= WRITE_DATA;
                            count_q <= 4'd7;
                        end else begin
                            ack_err_q <= ack_err_q | sda_in;
                            state_q   <= STOP;
                            scl_en_q  <= 1'b0;
                        end
`else
                        ack_err_q <= ack_err_q | sda_in;
                        state_q   <= STOP;
                        scl_en_q  <= 1'b0;
`endif
                    end
                    READ_DATA: begin
                        if (count_q != 4'd0) count_q <= count_q - 4'd1;
                        else                 state_q <= WRITE_ACK2;
                    end
                    WRITE_ACK2: begin
`ifdef I2C_MULTI_BYTE_EN
                        if (enable) begin
                            state_q <= READ_DATA;
                            count_q <= 4'd7;
                        end else begin
                            state_q  <= STOP;
                            scl_en_q <= 1'b0;
                        end
`else
                        state_q  <= STOP;
                        scl_en_q <= 1'b0;
`endif
                    end
                    STOP: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                    default: begin
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                        scl_en_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state       = state_q;
    assign count       = count_q;
    assign i2c_scl_en  = scl_en_q;
    assign i2c_scl     = scl_en_q ? scl_q : 1'b1;
    assign scl_negedge = scl_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign ack_err     = ack_err_q;
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Scoreboard bench for i2c_master_ctrl: a transaction-level model queues expected per-tick outputs.
`timescale 1ns/1ps
module tb_i2c_master_ctrl;
    localparam int CLK_DIV = 4;
    localparam int S_IDLE = 0, S_START = 1, S_ADDRESS = 2, S_READ_ACK = 3, S_WRITE_DATA = 4;
    localparam int S_READ_ACK2 = 5, S_READ_DATA = 6, S_WRITE_ACK2 = 7, S_STOP = 8;
`ifdef I2C_MULTI_BYTE_EN
    localparam bit MULTI = 1'b1;
`else
    localparam bit MULTI = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetN = 1'b1;
    logic       enable = 1'b0;
    logic       rw = 1'b0;
    logic       sda_in = 1'b1;
    logic [7:0] state;
    logic [3:0] count;
    logic       i2c_scl_en, i2c_scl, scl_negedge, busy, done, ack_err;

    i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .resetN(resetN), .enable(enable), .rw(rw), .sda_in(sda_in),
        .state(state), .count(count), .i2c_scl_en(i2c_scl_en), .i2c_scl(i2c_scl),
        .scl_negedge(scl_negedge), .busy(busy), .done(done), .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    // One entry per SCL rise tick: inputs to present before it, outputs expected after it.
    typedef struct {
        bit en; bit rwi; bit sda;
        int st; int cnt; bit scl_en; bit busy; bit err; bit done;
    } item_t;

    item_t plan_q[$];
    item_t exp_q[$];
    item_t mon_it;
    int    n_cmp = 0, n_bad = 0;
    int    m_cnt = 0;
    bit    m_err = 1'b0;
    int    exp_done_n = 0, act_done_n = 0;
    bit    mon_en = 1'b0;

    function automatic bit rb();
        return $urandom_range(0, 1) == 1;
    endfunction

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, expv, $time);
        end
    endtask

    function automatic void add(bit en, bit rwi, bit sda, int st, int cnt, bit scl_en, bit bsy, bit dn);
        item_t it;
        it.en = en; it.rwi = rwi; it.sda = sda;
        it.st = st; it.cnt = cnt; it.scl_en = scl_en; it.busy = bsy; it.err = m_err; it.done = dn;
        m_cnt = cnt;
        plan_q.push_back(it);
    endfunction

    function automatic void model_gap(int n);
        for (int i = 0; i < n; i++) add(1'b0, rb(), rb(), S_IDLE, m_cnt, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic void model_header(bit r);
        m_err = 1'b0;
        add(1'b1, r, rb(), S_START, m_cnt, 1'b0, 1'b1, 1'b0);
        for (int c = 7; c >= 0; c--) add(rb(), rb(), rb(), S_ADDRESS, c, 1'b1, 1'b1, 1'b0);
        add(rb(), rb(), rb(), S_READ_ACK, 0, 1'b1, 1'b1, 1'b0);
    endfunction

    // A whole transaction; enable/rw/sda are randomised wherever the protocol says they are ignored.
    function automatic void model_txn(bit r, bit anack, bit dnack, int nbytes);
        int ds, as;
        ds = r ? S_READ_DATA : S_WRITE_DATA;
        as = r ? S_WRITE_ACK2 : S_READ_ACK2;
        model_header(r);
        if (anack) begin
            m_err = 1'b1;
            add(rb(), rb(), 1'b1, S_STOP, 0, 1'b0, 1'b1, 1'b0);
        end else begin
            for (int b = 0; b < nbytes; b++) begin
                for (int c = 7; c >= 0; c--) begin
                    if (c == 7 && b == 0)  add(rb(), rb(), 1'b0, ds, 7, 1'b1, 1'b1, 1'b0);
                    else if (c == 7)       add(1'b1, rb(), r ? rb() : 1'b0, ds, 7, 1'b1, 1'b1, 1'b0);
                    else                   add(rb(), rb(), rb(), ds, c, 1'b1, 1'b1, 1'b0);
                end
                add(rb(), rb(), rb(), as, 0, 1'b1, 1'b1, 1'b0);
            end
            if (!r && dnack) begin
                m_err = 1'b1;
                add(rb(), rb(), 1'b1, S_STOP, 0, 1'b0, 1'b1, 1'b0);
            end else begin
                add(MULTI ? 1'b0 : rb(), rb(), r ? rb() : 1'b0, S_STOP, 0, 1'b0, 1'b1, 1'b0);
            end
        end
        add(rb(), rb(), rb(), S_IDLE, 0, 1'b0, 1'b0, 1'b1);
        exp_done_n++;
    endfunction

    // Write that is cut off by reset once WRITE_DATA reaches count 3.
    function automatic void model_abort();
        model_header(1'b0);
        add(rb(), rb(), 1'b0, S_WRITE_DATA, 7, 1'b1, 1'b1, 1'b0);
        for (int c = 6; c >= 3; c--) add(rb(), rb(), rb(), S_WRITE_DATA, c, 1'b1, 1'b1, 1'b0);
    endfunction

    task automatic run_plan();
        item_t it;
        while (plan_q.size() > 0) begin
            @(negedge scl_negedge);
            #1;
            it = plan_q.pop_front();
            enable = it.en;
            rw     = it.rwi;
            sda_in = it.sda;
            exp_q.push_back(it);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, int'(state), 0);
        check({tag, "_count"}, int'(count), 0);
        check({tag, "_scl"}, int'(i2c_scl), 1);
        check({tag, "_scl_en"}, int'(i2c_scl_en), 0);
        check({tag, "_scl_negedge"}, int'(scl_negedge), 1);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_ack_err"}, int'(ack_err), 0);
    endtask

    always @(posedge scl_negedge) begin
        #1;
        if (!resetN) begin
            mon_en = 1'b0;
        end else if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_tick: state %0d with no expectation queued at t=%0t", state, $time);
        end else begin
            mon_it = exp_q.pop_front();
            check("state", int'(state), mon_it.st);
            check("count", int'(count), mon_it.cnt);
            check("scl_en", int'(i2c_scl_en), int'(mon_it.scl_en));
            check("busy", int'(busy), int'(mon_it.busy));
            check("ack_err", int'(ack_err), int'(mon_it.err));
            check("done", int'(done), int'(mon_it.done));
            mon_en = mon_it.scl_en;
        end
    end

    // SCL low phase must reach the pin only while enabled.
    always @(negedge scl_negedge) begin
        #1;
        if (resetN) check("i2c_scl_low_phase", int'(i2c_scl), mon_en ? 0 : 1);
    end

    always @(negedge clk) begin
        if (resetN === 1'b1 && done === 1'b1) act_done_n++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete, %0d expectations pending", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit r, an, dn;
        int nb;
        #2 resetN = 1'b0;
        #1 check_reset_values("reset");
        repeat (2) @(negedge clk);
        resetN = 1'b1;

        model_txn(1'b0, 1'b0, 1'b0, 1); model_gap(1);
        model_txn(1'b1, 1'b0, 1'b0, 1);
        model_txn(1'b0, 1'b1, 1'b0, 1); model_gap(3);
        model_txn(1'b0, 1'b0, 1'b1, 1); model_gap(1);
        model_txn(1'b1, 1'b1, 1'b0, 1); model_gap(1);
        if (MULTI) begin
            model_txn(1'b0, 1'b0, 1'b0, 2); model_gap(1);
            model_txn(1'b1, 1'b0, 1'b0, 3); model_gap(1);
            model_txn(1'b0, 1'b0, 1'b1, 2); model_gap(1);
        end
        for (int t = 0; t < 20; t++) begin
            r  = rb();
            an = ($urandom_range(0, 5) == 0);
            dn = !r && ($urandom_range(0, 4) == 0);
            nb = MULTI ? int'($urandom_range(1, 3)) : 1;
            model_txn(r, an, dn, nb);
            model_gap(int'($urandom_range(0, 3)));
        end
        model_abort();
        run_plan();

        @(negedge scl_negedge);
        #3;
        check("queue_drained_pre_reset", exp_q.size(), 0);
        resetN = 1'b0;
        #1 check_reset_values("midreset");
        enable = 1'b1;
        rw = 1'b0;
        repeat (3) @(negedge clk);
        resetN = 1'b1;

        m_cnt = 0;
        m_err = 1'b0;
        model_txn(1'b0, 1'b0, 1'b0, 1);
        model_gap(2);
        run_plan();

        @(negedge scl_negedge);
        #2;
        check("queue_drained_end", exp_q.size(), 0);
        check("done_pulses", act_done_n, exp_done_n);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
